// File: rtl/hatch_if.sv
// hatch_if: control/status bundle between the incubation sequencer and its
// environment.
//   start      : one-cycle pulse, begin or restart incubation
//   stop       : abort to idle (level or pulse)
//   temp_in    : current temperature, unsigned degrees C
//   num        : stage number shown on the dot-matrix display
//   temp       : temperature-abnormal flag (red overlay)
//   st         : display enable, low only while idle
//   done       : high once the final hatched stage is reached
//   fail       : high after a sustained temperature excursion
//   stage_tick : one-cycle pulse on every stage advance
// master = stimulus/host side, slave = sequencer side.
interface hatch_if;
  logic       start;
  logic       stop;
  logic [6:0] temp_in;
  logic [3:0] num;
  logic       temp;
  logic       st;
  logic       done;
  logic       fail;
  logic       stage_tick;

  modport master (
    output start, stop, temp_in,
    input  num, temp, st, done, fail, stage_tick
  );

  modport slave (
    input  start, stop, temp_in,
    output num, temp, st, done, fail, stage_tick
  );
endinterface

// File: rtl/hatch_ctrl.sv
// hatch_ctrl: incubation sequencer for the egg-hatch display.
// Walks the hatching timeline one stage every STAGE_SEC seconds while the
// temperature stays within [TEMP_LO, TEMP_HI]; pauses while it is out of
// range and declares failure after FAIL_SEC consecutive bad seconds.
// Ports:
//   clk : system clock (CLK_HZ cycles per second)
//   rst : synchronous reset, active-high
//   bus : hatch_if.slave (start/stop/temp_in in; num/temp/st/done/fail/
//         stage_tick out, all registered)
module hatch_ctrl #(
  parameter int CLK_HZ     = 1000,
  parameter int STAGE_SEC  = 3,
  parameter int LAST_STAGE = 11,
  parameter int TEMP_LO    = 37,
  parameter int TEMP_HI    = 39,
  parameter int FAIL_SEC   = 5
) (
  input  logic    clk,
  input  logic    rst,
  hatch_if.slave  bus
);

  localparam int PRE_W = (CLK_HZ    > 1) ? $clog2(CLK_HZ)    : 1;
  localparam int SEC_W = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
  localparam int BAD_W = (FAIL_SEC  > 1) ? $clog2(FAIL_SEC)  : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(STAGE_SEC - 1);
  localparam logic [BAD_W-1:0] BAD_MAX  = BAD_W'(FAIL_SEC - 1);
  localparam logic [3:0]       NUM_LAST = 4'(LAST_STAGE);
  localparam logic [6:0]       T_LO     = 7'(TEMP_LO);
  localparam logic [6:0]       T_HI     = 7'(TEMP_HI);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INCUBATE = 3'd1;
  localparam logic [2:0] PAUSE    = 3'd2;
  localparam logic [2:0] HATCHED  = 3'd3;
  localparam logic [2:0] FAILED   = 3'd4;

  logic [2:0]       state;
  logic [PRE_W-1:0] pre;
  logic [SEC_W-1:0] sec_cnt;
  logic [BAD_W-1:0] bad_cnt;
  logic [3:0]       stage_num;
  logic             temp_flag;
  logic             disp_en;
  logic             done_flag;
  logic             fail_flag;
  logic             tick;

  logic             ok;
  logic             sec_tick;
  logic             begin_run;
  logic [PRE_W-1:0] pre_next;
  logic [3:0]       num_inc;

  assign ok        = (bus.temp_in >= T_LO) && (bus.temp_in <= T_HI);
  assign sec_tick  = (pre == PRE_MAX);
  assign pre_next  = sec_tick ? '0 : pre + 1'b1;
  assign num_inc   = stage_num + 4'd1;
  // start is honoured only from the resting states; a run in progress
  // (INCUBATE or PAUSE) ignores it.
  assign begin_run = bus.start &&
                     ((state == IDLE) || (state == HATCHED) || (state == FAILED));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre       <= '0;
      sec_cnt   <= '0;
      bad_cnt   <= '0;
      stage_num <= '0;
      temp_flag <= 1'b0;
      disp_en   <= 1'b0;
      done_flag <= 1'b0;
      fail_flag <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (bus.stop) begin
        state     <= IDLE;
        pre       <= '0;
        sec_cnt   <= '0;
        bad_cnt   <= '0;
        stage_num <= '0;
        temp_flag <= 1'b0;
        disp_en   <= 1'b0;
        done_flag <= 1'b0;
        fail_flag <= 1'b0;
      end else if (begin_run) begin
        state     <= INCUBATE;
        pre       <= '0;
        sec_cnt   <= '0;
        bad_cnt   <= '0;
        stage_num <= '0;
        temp_flag <= 1'b0;
        disp_en   <= 1'b1;
        done_flag <= 1'b0;
        fail_flag <= 1'b0;
      end else begin
        case (state)
          INCUBATE: begin
            if (!ok) begin
              // Pause wins over a coincident second tick: prescaler and
              // stage timer hold so no progress is lost or gained.
              state     <= PAUSE;
              temp_flag <= 1'b1;
            end else begin
              pre <= pre_next;
              if (sec_tick) begin
                if (sec_cnt == SEC_MAX) begin
                  sec_cnt   <= '0;
                  stage_num <= num_inc;
                  tick      <= 1'b1;
                  if (num_inc == NUM_LAST) begin
                    state     <= HATCHED;
                    done_flag <= 1'b1;
                  end
                end else begin
                  sec_cnt <= sec_cnt + 1'b1;
                end
              end
            end
          end
          PAUSE: begin
            // The prescaler keeps running so bad seconds are timed on the
            // same second grid; the stage timer stays frozen.
            pre <= pre_next;
            if (ok) begin
              state     <= INCUBATE;
              temp_flag <= 1'b0;
              bad_cnt   <= '0;
            end else if (sec_tick) begin
              if (bad_cnt == BAD_MAX) begin
                state     <= FAILED;
                fail_flag <= 1'b1;
              end else begin
                bad_cnt <= bad_cnt + 1'b1;
              end
            end
          end
          IDLE, HATCHED, FAILED: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.num        = stage_num;
  assign bus.temp       = temp_flag;
  assign bus.st         = disp_en;
  assign bus.done       = done_flag;
  assign bus.fail       = fail_flag;
  assign bus.stage_tick = tick;

endmodule

// File: tb/tb_hatch_ctrl.sv
// tb_hatch_ctrl: directed scoreboard bench for hatch_ctrl with a compressed
// timeline (CLK_HZ=4, STAGE_SEC=2, LAST_STAGE=3, FAIL_SEC=3). The stimulus
// process queues the hand-derived output vector expected after a given
// clock edge; the monitor compares each entry on the falling edge of that
// cycle.
module tb_hatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  hatch_if bus ();

  hatch_ctrl #(
    .CLK_HZ(4), .STAGE_SEC(2), .LAST_STAGE(3),
    .TEMP_LO(37), .TEMP_HI(39), .FAIL_SEC(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] num;
    logic       temp;
    logic       st;
    logic       done;
    logic       fail;
    logic       tick;
  } exp_t;

  exp_t sbq[$];

  task automatic expect_at(input int c, input string nm, input logic [3:0] n,
                           input logic t, input logic s, input logic d,
                           input logic f, input logic k);
    exp_t e;
    e.cyc = c; e.name = nm; e.num = n;
    e.temp = t; e.st = s; e.done = d; e.fail = f; e.tick = k;
    sbq.push_back(e);
  endtask

  task automatic expect_run(input int base, input int k0, input int k1,
                            input string nm, input logic [3:0] n,
                            input logic t, input logic s, input logic d,
                            input logic f, input logic k);
    for (int i = k0; i <= k1; i++) expect_at(base + i, nm, n, t, s, d, f, k);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: outputs are continuous, so every cycle is a presentation;
  // entries due this cycle are popped and compared.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                 e.name, e.cyc, cyc);
      end else if ({bus.num, bus.temp, bus.st, bus.done, bus.fail, bus.stage_tick} !==
                   {e.num, e.temp, e.st, e.done, e.fail, e.tick}) begin
        errors++;
        $display("FAIL %s @%0d: got num=%0d temp=%b st=%b done=%b fail=%b tick=%b, expected num=%0d temp=%b st=%b done=%b fail=%b tick=%b",
                 e.name, cyc, bus.num, bus.temp, bus.st, bus.done, bus.fail,
                 bus.stage_tick, e.num, e.temp, e.st, e.done, e.fail, e.tick);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int s;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.temp_in = 7'd38;
    @(negedge clk);

    // Reset state and idle after reset release.
    expect_at(cyc + 1, "reset", 4'd0, 0, 0, 0, 0, 0);
    wait_cyc(2);
    rst = 1'b0;
    expect_at(3, "idle", 4'd0, 0, 0, 0, 0, 0);
    wait_cyc(4);

    // Full run at 38 C: ticks at 8/16/24, hatch at 24, num holds 3.
    s = cyc + 1;
    expect_run(s, 0, 7,   "run_s0",  4'd0, 0, 1, 0, 0, 0);
    expect_at (s + 8,     "run_adv1", 4'd1, 0, 1, 0, 0, 1);
    expect_run(s, 9, 15,  "run_s1",  4'd1, 0, 1, 0, 0, 0);
    expect_at (s + 16,    "run_adv2", 4'd2, 0, 1, 0, 0, 1);
    expect_run(s, 17, 23, "run_s2",  4'd2, 0, 1, 0, 0, 0);
    expect_at (s + 24,    "run_hatch", 4'd3, 0, 1, 1, 0, 1);
    expect_run(s, 25, 30, "run_hold", 4'd3, 0, 1, 1, 0, 0);
    pulse_start();
    wait_cyc(s + 31);

    // Excursion to 40 C seen on edges 6..11: temp=1 cycles 6..11, num
    // frozen; the shared prescaler reaches its tick right after resuming,
    // so the first advance lands at 13. Then stop+start at num=2.
    s = cyc + 1;
    expect_run(s, 0, 5,   "exc_pre",   4'd0, 0, 1, 0, 0, 0);
    expect_run(s, 6, 11,  "exc_pause", 4'd0, 1, 1, 0, 0, 0);
    expect_at (s + 12,    "exc_resume", 4'd0, 0, 1, 0, 0, 0);
    expect_at (s + 13,    "exc_adv1",  4'd1, 0, 1, 0, 0, 1);
    expect_run(s, 14, 20, "exc_s1",    4'd1, 0, 1, 0, 0, 0);
    expect_at (s + 21,    "exc_adv2",  4'd2, 0, 1, 0, 0, 1);
    expect_run(s, 23, 25, "stop_idle", 4'd0, 0, 0, 0, 0, 0);
    pulse_start();
    wait_cyc(s + 5);
    bus.temp_in = 7'd40;
    wait_cyc(s + 11);
    bus.temp_in = 7'd38;
    wait_cyc(s + 22);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    wait_cyc(s + 26);

    // 30 C from cycle 1: pause at 2, fail after third bad second (13);
    // restart clears fail; then 36 C pause, reset mid-pause, fresh start
    // times a full stage; boundary 37/39 stay ok, 40 pauses.
    s = cyc + 1;
    expect_run(s, 0, 1,   "cold_pre",   4'd0, 0, 1, 0, 0, 0);
    expect_run(s, 2, 12,  "cold_pause", 4'd0, 1, 1, 0, 0, 0);
    expect_run(s, 13, 14, "cold_fail",  4'd0, 1, 1, 0, 1, 0);
    expect_run(s, 15, 18, "restart",    4'd0, 0, 1, 0, 0, 0);
    expect_run(s, 19, 21, "t36_pause",  4'd0, 1, 1, 0, 0, 0);
    expect_at (s + 22,    "rst_pause",  4'd0, 0, 0, 0, 0, 0);
    expect_run(s, 23, 30, "new_s0",     4'd0, 0, 1, 0, 0, 0);
    expect_at (s + 31,    "new_adv1",   4'd1, 0, 1, 0, 0, 1);
    expect_run(s, 32, 38, "bound_ok",   4'd1, 0, 1, 0, 0, 0);
    expect_at (s + 39,    "bound_adv2", 4'd2, 0, 1, 0, 0, 1);
    expect_at (s + 40,    "bound_39",   4'd2, 0, 1, 0, 0, 0);
    expect_run(s, 41, 42, "t40_pause",  4'd2, 1, 1, 0, 0, 0);
    pulse_start();
    wait_cyc(s + 1);
    bus.temp_in = 7'd30;
    wait_cyc(s + 14);
    bus.temp_in = 7'd38;
    pulse_start();
    wait_cyc(s + 18);
    bus.temp_in = 7'd36;
    wait_cyc(s + 21);
    rst = 1'b1;
    wait_cyc(s + 22);
    rst = 1'b0;
    bus.temp_in = 7'd38;
    pulse_start();
    wait_cyc(s + 31);
    bus.temp_in = 7'd37;
    wait_cyc(s + 33);
    bus.temp_in = 7'd39;
    wait_cyc(s + 40);
    bus.temp_in = 7'd40;
    wait_cyc(s + 44);

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
